cpu_ctrl_fsm: RTL and testbench

//  Parametrised successor to the board-level CPU run/stop controller. It debounces the

---
 rtl/cpu_ctrl_fsm_pkg.sv | 19 +
 rtl/cpu_ctrl_fsm_debounce.sv | 45 ++++
 rtl/cpu_ctrl_fsm.sv | 152 +++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared encodings for the CPU run/stop controller.
package cpu_ctrl_fsm_pkg;

    typedef enum logic [1:0] {
        COM_RST = 2'd0,
        COM_RUN = 2'd1,
        COM_STP = 2'd2
    } com_state_e;

    // Probe ROM header code marking the end of the probe table.
    localparam logic [3:0] MEM_END = 4'hF;

    // Key roles (index into the debounced pulse vector).
    localparam int unsigned K_RUN   = 0;
    localparam int unsigned K_PAUSE = 1;
    localparam int unsigned K_CLR   = 2;
    localparam int unsigned K_INC   = 3;

endpackage

// File: rtl/cpu_ctrl_fsm_debounce.sv
// Single pushbutton debouncer: 2-FF synchroniser, stability counter,
// registered one-cycle strobe on an accepted press (level 1 -> 0).
module key_debounce #(
    parameter int unsigned DEB_CYC = 16,
    parameter int unsigned DEB_W   = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_pulse
);

    logic [1:0]       r_sync;
    logic             r_lvl;
    logic [DEB_W-1:0] r_cnt;
    logic             r_pulse;

    // Synchronise, count consecutive differing samples, accept and strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '1;
            r_lvl   <= 1'b1;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_key_n};
            r_pulse <= 1'b0;
            if (r_sync[1] != r_lvl) begin
                if (r_cnt == DEB_W'(DEB_CYC - 1)) begin
                    r_lvl   <= r_sync[1];
                    r_cnt   <= '0;
                    // old level 1 means the new accepted level is a press
                    r_pulse <= r_lvl;
                end else begin
                    r_cnt <= r_cnt + DEB_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// CPU run/stop controller: debounced keys, RST/RUN/STP sequencing,
// breakpoints, N-instruction stepping and probe/console address stepping.
module cpu_ctrl_fsm
    import cpu_ctrl_fsm_pkg::*;
#(
    parameter int unsigned AW      = 12,
    parameter int unsigned NUM_BP  = 2,
    parameter int unsigned STEP_W  = 8,
    parameter int unsigned DEB_CYC = 16,
    parameter int unsigned DEB_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           key_n,
    input  logic [3:0]           sm,
    input  logic                 insn_end,
    input  logic                 intr_detected,
    input  logic                 halted,
    input  logic [AW-1:0]        pc,
    input  logic [NUM_BP*AW-1:0] bp_addr,
    input  logic [NUM_BP-1:0]    bp_en,
    input  logic [STEP_W-1:0]    step_cnt,
    input  logic [31:0]          probe_info,
    output logic [1:0]           cpu_state,
    output logic [AW-1:0]        com_addr_reg,
    output logic [AW-1:0]        probe_idx,
    output logic [NUM_BP-1:0]    bp_hit,
    output logic [3:0]           key_pulse
);

    com_state_e        r_state, w_state_nx;
    logic [AW-1:0]     r_com_addr, w_addr_nx;
    logic [AW-1:0]     r_probe_idx, w_idx_nx;
    logic [NUM_BP-1:0] r_bp_hit, w_bp_nx;
    logic [STEP_W-1:0] r_step, w_step_nx;

    logic [3:0]        w_kp;
    logic [NUM_BP-1:0] w_bp_eq;
    logic [NUM_BP-1:0] w_bp_match;
    logic [STEP_W-1:0] w_step_load;
    logic [3:0]        w_hdr;
    logic [AW-1:0]     w_paddr;
    logic              w_stop;
    logic              w_unused;

    for (genvar g = 0; g < 4; g++) begin : g_deb
        key_debounce #(
            .DEB_CYC (DEB_CYC),
            .DEB_W   (DEB_W)
        ) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_key_n (key_n[g]),
            .o_pulse (w_kp[g])
        );
    end

    for (genvar b = 0; b < NUM_BP; b++) begin : g_bp
        assign w_bp_eq[b] = bp_en[b] && (pc == bp_addr[b*AW +: AW]);
    end

    assign w_bp_match  = insn_end ? w_bp_eq : '0;
    assign w_step_load = (step_cnt == '0) ? STEP_W'(1) : step_cnt;
    assign w_hdr       = probe_info[31:28];
    assign w_paddr     = probe_info[AW+15:16];
    assign w_unused    = ^probe_info;

    assign w_stop = w_kp[K_PAUSE] | halted | sm[2] | (sm[1] & intr_detected)
                  | (sm[3] & insn_end & (r_step == STEP_W'(1))) | (|w_bp_match);

    // Next-state and register updates for all controller state.
    always_comb begin
        w_state_nx = r_state;
        w_addr_nx  = r_com_addr;
        w_idx_nx   = r_probe_idx;
        w_bp_nx    = r_bp_hit;
        w_step_nx  = r_step;
        case (r_state)
            COM_RST: begin
                w_addr_nx = '0;
                w_idx_nx  = '0;
                if (w_kp[K_RUN]) begin
                    w_state_nx = COM_RUN;
                    w_step_nx  = w_step_load;
                end else if (w_kp[K_PAUSE]) begin
                    w_state_nx = COM_STP;
                end
            end
            COM_RUN: begin
                if (insn_end && (r_step > STEP_W'(1))) begin
                    w_step_nx = r_step - STEP_W'(1);
                end
                if (w_kp[K_RUN]) begin
                    w_state_nx = COM_RST;
                end else if (w_stop) begin
                    w_state_nx = COM_STP;
                    w_bp_nx    = w_bp_match;
                end
            end
            COM_STP: begin
                if (w_kp[K_RUN]) begin
                    w_state_nx = COM_RST;
                end else if (w_kp[K_PAUSE]) begin
                    w_state_nx = COM_RUN;
                    w_step_nx  = w_step_load;
                    w_bp_nx    = '0;
                end
                if (halted) begin
                    if (w_kp[K_CLR] || (w_hdr == MEM_END)) begin
                        w_idx_nx = '0;
                    end else if (w_kp[K_INC]) begin
                        w_idx_nx = r_probe_idx + AW'(1);
                    end
                    w_addr_nx = w_paddr;
                end else begin
                    if (w_kp[K_CLR]) begin
                        w_addr_nx = '0;
                    end else if (w_kp[K_INC]) begin
                        w_addr_nx = r_com_addr + AW'(1);
                    end
                end
            end
            default: begin
                w_state_nx = COM_RST;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= COM_RST;
            r_com_addr  <= '0;
            r_probe_idx <= '0;
            r_bp_hit    <= '0;
            r_step      <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_com_addr  <= w_addr_nx;
            r_probe_idx <= w_idx_nx;
            r_bp_hit    <= w_bp_nx;
            r_step      <= w_step_nx;
        end
    end

    assign cpu_state    = r_state;
    assign com_addr_reg = r_com_addr;
    assign probe_idx    = r_probe_idx;
    assign bp_hit       = r_bp_hit;
    assign key_pulse    = w_kp;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: a vector table for the key/mode
// sequencing plus hand-written multi-cycle sequences.
module tb_cpu_ctrl_fsm;

    localparam int unsigned AW      = 8;
    localparam int unsigned NUM_BP  = 2;
    localparam int unsigned STEP_W  = 8;
    localparam int unsigned DEB_CYC = 16;
    localparam int unsigned DEB_W   = 5;

    localparam logic [1:0] SR = 2'd0;
    localparam logic [1:0] SU = 2'd1;
    localparam logic [1:0] SP = 2'd2;

    localparam logic [3:0] K0 = 4'b0001;
    localparam logic [3:0] K1 = 4'b0010;
    localparam logic [3:0] K2 = 4'b0100;
    localparam logic [3:0] K3 = 4'b1000;

    localparam logic [31:0] PINFO = 32'h10A5_0000;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [3:0]           key_n;
    logic [3:0]           sm;
    logic                 insn_end;
    logic                 intr_detected;
    logic                 halted;
    logic [AW-1:0]        pc;
    logic [NUM_BP*AW-1:0] bp_addr;
    logic [NUM_BP-1:0]    bp_en;
    logic [STEP_W-1:0]    step_cnt;
    logic [31:0]          probe_info;
    logic [1:0]           cpu_state;
    logic [AW-1:0]        com_addr_reg;
    logic [AW-1:0]        probe_idx;
    logic [NUM_BP-1:0]    bp_hit;
    logic [3:0]           key_pulse;

    int total = 0;
    int bad   = 0;

    cpu_ctrl_fsm #(
        .AW      (AW),
        .NUM_BP  (NUM_BP),
        .STEP_W  (STEP_W),
        .DEB_CYC (DEB_CYC),
        .DEB_W   (DEB_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_n         (key_n),
        .sm            (sm),
        .insn_end      (insn_end),
        .intr_detected (intr_detected),
        .halted        (halted),
        .pc            (pc),
        .bp_addr       (bp_addr),
        .bp_en         (bp_en),
        .step_cnt      (step_cnt),
        .probe_info    (probe_info),
        .cpu_state     (cpu_state),
        .com_addr_reg  (com_addr_reg),
        .probe_idx     (probe_idx),
        .bp_hit        (bp_hit),
        .key_pulse     (key_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] keys;
        logic [3:0] sm;
        logic       h;
        logic       intr;
        logic [1:0] st;
        logic [7:0] addr;
        logic [7:0] idx;
    } vec_t;

    vec_t tbl[25];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Press the keys in m together, wait for the strobe, then release and settle.
    task automatic press(input logic [3:0] m);
        int n;
        n = 0;
        key_n = ~m;
        while (key_pulse == 4'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("key_pulse", key_pulse, m);
        key_n = '1;
        repeat (DEB_CYC + 4) @(negedge clk);
    endtask

    task automatic strobe();
        @(negedge clk);
        insn_end = 1'b1;
        @(negedge clk);
        insn_end = 1'b0;
    endtask

    initial begin
        int lat;
        int np;
        logic [9:0] glitch;

        tbl[0]  = '{4'h0,    4'b0001, 1'b0, 1'b0, SR, 8'h00, 8'h00};
        tbl[1]  = '{K0,      4'b0001, 1'b0, 1'b0, SU, 8'h00, 8'h00};
        tbl[2]  = '{K1,      4'b0001, 1'b0, 1'b0, SP, 8'h00, 8'h00};
        tbl[3]  = '{K3,      4'b0001, 1'b0, 1'b0, SP, 8'h01, 8'h00};
        tbl[4]  = '{K3,      4'b0001, 1'b0, 1'b0, SP, 8'h02, 8'h00};
        tbl[5]  = '{K2,      4'b0001, 1'b0, 1'b0, SP, 8'h00, 8'h00};
        tbl[6]  = '{4'h0,    4'b0001, 1'b1, 1'b0, SP, 8'hA5, 8'h00};
        tbl[7]  = '{K3,      4'b0001, 1'b1, 1'b0, SP, 8'hA5, 8'h01};
        tbl[8]  = '{K3,      4'b0001, 1'b1, 1'b0, SP, 8'hA5, 8'h02};
        tbl[9]  = '{K2,      4'b0001, 1'b1, 1'b0, SP, 8'hA5, 8'h00};
        tbl[10] = '{K1,      4'b0001, 1'b0, 1'b0, SU, 8'hA5, 8'h00};
        tbl[11] = '{4'h0,    4'b0100, 1'b0, 1'b0, SP, 8'hA5, 8'h00};
        tbl[12] = '{K1,      4'b0001, 1'b0, 1'b0, SU, 8'hA5, 8'h00};
        tbl[13] = '{4'h0,    4'b0001, 1'b1, 1'b0, SP, 8'hA5, 8'h00};
        tbl[14] = '{K1,      4'b0010, 1'b0, 1'b0, SU, 8'hA5, 8'h00};
        tbl[15] = '{4'h0,    4'b0010, 1'b0, 1'b1, SP, 8'hA5, 8'h00};
        tbl[16] = '{K1,      4'b0001, 1'b0, 1'b0, SU, 8'hA5, 8'h00};
        tbl[17] = '{K0 | K1, 4'b0001, 1'b0, 1'b0, SR, 8'h00, 8'h00};
        tbl[18] = '{K0,      4'b0001, 1'b0, 1'b0, SU, 8'h00, 8'h00};
        tbl[19] = '{K1,      4'b0001, 1'b0, 1'b0, SP, 8'h00, 8'h00};
        tbl[20] = '{K3,      4'b0001, 1'b0, 1'b0, SP, 8'h01, 8'h00};
        tbl[21] = '{K2 | K3, 4'b0001, 1'b0, 1'b0, SP, 8'h00, 8'h00};
        tbl[22] = '{K0,      4'b0001, 1'b0, 1'b0, SR, 8'h00, 8'h00};
        tbl[23] = '{K1,      4'b0001, 1'b0, 1'b0, SP, 8'h00, 8'h00};
        tbl[24] = '{K0,      4'b0001, 1'b0, 1'b0, SR, 8'h00, 8'h00};

        rst_n         = 1'b0;
        key_n         = '1;
        sm            = 4'b0001;
        insn_end      = 1'b0;
        intr_detected = 1'b0;
        halted        = 1'b0;
        pc            = '0;
        bp_addr       = '0;
        bp_en         = '0;
        step_cnt      = 8'd3;
        probe_info    = PINFO;
        repeat (3) @(negedge clk);
        chk("rst_bp_hit", bp_hit, '0);
        chk("rst_key_pulse", key_pulse, '0);
        rst_n = 1'b1;

        // Table-driven key/mode sequencing.
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            sm            = tbl[i].sm;
            halted        = tbl[i].h;
            intr_detected = tbl[i].intr;
            if (tbl[i].keys != 4'h0) press(tbl[i].keys);
            else repeat (3) @(negedge clk);
            chk($sformatf("row%0d_state", i), cpu_state,    tbl[i].st);
            chk($sformatf("row%0d_addr", i),  com_addr_reg, tbl[i].addr);
            chk($sformatf("row%0d_idx", i),   probe_idx,    tbl[i].idx);
        end

        // Bouncing K3 shorter than the debounce window gives no strobe.
        glitch = 10'b0100001000;
        np = 0;
        for (int i = 9; i >= 0; i--) begin
            key_n[3] = glitch[i];
            @(negedge clk);
            if (key_pulse != 4'b0) np++;
        end
        key_n[3] = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (key_pulse != 4'b0) np++;
        end
        chk("glitch_no_pulse", np, 0);

        // Stable press: strobe visible 2+DEB_CYC cycles later.
        key_n[3] = 1'b0;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (key_pulse[3] && lat < 0) lat = i;
        end
        chk("deb_latency", lat, 2 + DEB_CYC);
        key_n[3] = 1'b1;
        repeat (DEB_CYC + 4) @(negedge clk);

        // N-instruction stepping.
        sm = 4'b1000;
        step_cnt = 8'd3;
        press(K0);
        chk("step_run", cpu_state, SU);
        strobe();
        chk("step_1", cpu_state, SU);
        strobe();
        chk("step_2", cpu_state, SU);
        strobe();
        chk("step_3", cpu_state, SP);
        strobe();
        strobe();
        chk("step_5", cpu_state, SP);
        step_cnt = 8'd0;
        press(K1);
        chk("step0_run", cpu_state, SU);
        strobe();
        chk("step0_1", cpu_state, SP);

        // Breakpoints: only the enabled comparator may hit.
        sm      = 4'b0001;
        step_cnt = 8'd3;
        bp_en   = 2'b10;
        bp_addr = {8'h25, 8'h25};
        pc      = 8'h24;
        press(K1);
        chk("bp_run", cpu_state, SU);
        strobe();
        chk("bp_miss", cpu_state, SU);
        pc = 8'h25;
        repeat (3) @(negedge clk);
        chk("bp_no_insn", cpu_state, SU);
        strobe();
        chk("bp_stop", cpu_state, SP);
        chk("bp_hit", bp_hit, 2'b10);
        press(K1);
        chk("bp_rerun", cpu_state, SU);
        chk("bp_clear", bp_hit, 2'b00);
        pc = 8'h00;
        press(K1);
        chk("pause_state", cpu_state, SP);
        chk("pause_bp_hit", bp_hit, 2'b00);
        bp_en = 2'b00;

        // Probe index stepping while halted.
        halted = 1'b1;
        for (int i = 0; i < 255; i++) press(K3);
        chk("idx_ff", probe_idx, 8'hFF);
        press(K3);
        chk("idx_wrap", probe_idx, 8'h00);
        press(K3);
        press(K3);
        chk("idx_2", probe_idx, 8'h02);
        probe_info = 32'hF03C_0000;
        repeat (2) @(negedge clk);
        chk("idx_mem_end", probe_idx, 8'h00);
        chk("addr_probe", com_addr_reg, 8'h3C);
        probe_info = PINFO;
        press(K3);
        chk("idx_1", probe_idx, 8'h01);
        press(K2 | K3);
        chk("idx_clr_beats_inc", probe_idx, 8'h00);
        press(K3);
        chk("idx_pre_rst", probe_idx, 8'h01);

        // Asynchronous reset mid-RUN, K0 held across release.
        halted = 1'b0;
        press(K1);
        chk("pre_rst_run", cpu_state, SU);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_state", cpu_state, SR);
        chk("async_idx", probe_idx, 8'h00);
        chk("async_addr", com_addr_reg, 8'h00);
        key_n[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        np = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (key_pulse[0]) np++;
        end
        chk("held_k0_pulses", np, 1);
        chk("held_k0_run", cpu_state, SU);
        key_n = '1;
        repeat (DEB_CYC + 4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
